// File: rtl/isa_pkg.sv
// isa_pkg: shared 9-bit ISA definitions (opcodes / ALU command encodings, FSM states, HALT encoding, flag-updating op set)
package isa_pkg;
    // Opcode values double as the ALU command encodings seen by the ALU
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_LSL = 3'b001,
        OP_BRF = 3'b010,
        OP_XOR = 3'b011,
        OP_LI  = 3'b100,
        OP_LSR = 3'b101,
        OP_SUB = 3'b110,
        OP_CMP = 3'b111
    } opcode_t;
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_DONE
    } state_t;
    localparam logic [8:0] HALT_INSTR = 9'b100_111111;
    // One bit per opcode: LSL, SUB and CMP load the flag register
    localparam logic [7:0] FLAG_OPS = 8'b1100_0010;
    function automatic logic is_flag_op(input opcode_t op);
        return FLAG_OPS[op];
    endfunction
endpackage

// File: rtl/isa_ctrl_sequencer_if.sv
// isa_ctrl_sequencer_if: start/status, instruction ROM and ALU/register-file control bundle
//   master (sequencer): drives instr_addr, alu_cmd, ra_sel, rb_sel, rf_we, rf_wsel, wdata_sel, imm, busy, done
//   slave (environment): drives start, instr_data, alu_flag
interface isa_ctrl_sequencer_if #(parameter int PC_W = 8, parameter int DATA_W = 9);
    logic              start;
    logic [PC_W-1:0]   instr_addr;
    logic [DATA_W-1:0] instr_data;
    logic [2:0]        alu_cmd;
    logic [2:0]        ra_sel;
    logic [2:0]        rb_sel;
    logic              rf_we;
    logic [2:0]        rf_wsel;
    logic              wdata_sel;
    logic [DATA_W-1:0] imm;
    logic              alu_flag;
    logic              busy;
    logic              done;
    modport master (
        input  start, instr_data, alu_flag,
        output instr_addr, alu_cmd, ra_sel, rb_sel, rf_we, rf_wsel, wdata_sel, imm, busy, done
    );
    modport slave (
        output start, instr_data, alu_flag,
        input  instr_addr, alu_cmd, ra_sel, rb_sel, rf_we, rf_wsel, wdata_sel, imm, busy, done
    );
endinterface

// File: rtl/isa_ctrl_sequencer_decode.sv
// isa_decode: combinational instruction decode, IR -> datapath controls plus branch/halt/flag-update hints
//   in : ir[8:0]
//   out: alu_cmd, ra_sel, rb_sel, rf_we, rf_wsel, wdata_sel, imm, is_brf, is_halt, flag_upd
module isa_decode
    import isa_pkg::*;
(
    input  logic [8:0] ir,
    output logic [2:0] alu_cmd,
    output logic [2:0] ra_sel,
    output logic [2:0] rb_sel,
    output logic       rf_we,
    output logic [2:0] rf_wsel,
    output logic       wdata_sel,
    output logic [8:0] imm,
    output logic       is_brf,
    output logic       is_halt,
    output logic       flag_upd
);
    opcode_t op;
    logic    is_alu;
    logic    is_li;
    assign op        = opcode_t'(ir[8:6]);
    assign is_halt   = ir == HALT_INSTR;
    assign is_brf    = op == OP_BRF;
    assign is_li     = op == OP_LI && !is_halt;
    assign is_alu    = op != OP_BRF && op != OP_LI;
    assign alu_cmd   = is_alu ? op : 3'b000;
    assign ra_sel    = is_alu ? ir[5:3] : 3'd0;
    assign rb_sel    = is_alu ? ir[2:0] : 3'd0;
    // LI always targets r0, so only ALU ops carry a write index
    assign rf_wsel   = is_alu ? ir[5:3] : 3'd0;
    assign rf_we     = (is_alu && op != OP_CMP) || is_li;
    assign wdata_sel = is_li;
    assign imm       = is_li ? {3'b000, ir[5:0]} : 9'd0;
    assign flag_upd  = is_flag_op(op);
endmodule

// File: rtl/isa_ctrl_sequencer.sv
// isa_ctrl_sequencer: 3-cycle fetch/decode/exec control unit for the 9-bit ISA
//   clk, rst_n (async, active low); bus (master): ROM address/data, ALU/register-file controls, alu_flag, start/busy/done
module isa_ctrl_sequencer
    import isa_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int DATA_W = 9
) (
    input logic                  clk,
    input logic                  rst_n,
    isa_ctrl_sequencer_if.master bus
);
    state_t            state, state_n;
    logic [PC_W-1:0]   pc, pc_n;
    logic [DATA_W-1:0] ir;
    logic              flag, flag_n;
    logic              exec;
    logic [2:0]        d_alu_cmd, d_ra_sel, d_rb_sel, d_rf_wsel;
    logic              d_rf_we, d_wdata_sel, is_brf, is_halt, flag_upd;
    logic [8:0]        d_imm;

    isa_decode u_decode (
        .ir        (ir),
        .alu_cmd   (d_alu_cmd),
        .ra_sel    (d_ra_sel),
        .rb_sel    (d_rb_sel),
        .rf_we     (d_rf_we),
        .rf_wsel   (d_rf_wsel),
        .wdata_sel (d_wdata_sel),
        .imm       (d_imm),
        .is_brf    (is_brf),
        .is_halt   (is_halt),
        .flag_upd  (flag_upd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= '0;
            ir    <= '0;
            flag  <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            flag  <= flag_n;
            if (state == S_DECODE) ir <= bus.instr_data;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        flag_n  = flag;
        case (state)
            S_IDLE: if (bus.start) begin
                state_n = S_FETCH;
                pc_n    = '0;
            end
            S_FETCH:  state_n = S_DECODE;
            S_DECODE: state_n = S_EXEC;
            S_EXEC: begin
                state_n = is_halt ? S_DONE : S_FETCH;
                // BRF tests the flag as it stood before this EXEC
                pc_n    = is_halt ? pc : (is_brf && flag) ? pc + PC_W'($signed(ir[5:0])) : pc + PC_W'(1);
                flag_n  = flag_upd ? bus.alu_flag : flag;
            end
            S_DONE: if (bus.start) begin
                state_n = S_FETCH;
                pc_n    = '0;
                flag_n  = 1'b0;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign exec          = state == S_EXEC;
    assign bus.instr_addr = pc;
    assign bus.alu_cmd   = exec ? d_alu_cmd : 3'b000;
    assign bus.ra_sel    = exec ? d_ra_sel : 3'd0;
    assign bus.rb_sel    = exec ? d_rb_sel : 3'd0;
    assign bus.rf_we     = exec && d_rf_we;
    assign bus.rf_wsel   = exec ? d_rf_wsel : 3'd0;
    assign bus.wdata_sel = exec && d_wdata_sel;
    assign bus.imm       = exec ? DATA_W'(d_imm) : '0;
    assign bus.busy      = state == S_FETCH || state == S_DECODE || state == S_EXEC;
    assign bus.done      = state == S_DONE;
endmodule

// File: tb/tb_isa_ctrl_sequencer.sv
// tb_isa_ctrl_sequencer: directed self-checking bench with a synchronous ROM model
module tb_isa_ctrl_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] rom [256];
    int         checks = 0;
    int         errors = 0;

    isa_ctrl_sequencer_if #(.PC_W(8), .DATA_W(9)) bus ();
    isa_ctrl_sequencer #(.PC_W(8), .DATA_W(9)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) bus.instr_data <= rom[bus.instr_addr];

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.alu_flag = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 9'd0;
        tick(2);
        chk("rst_addr", 32'(bus.instr_addr), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_ctrl", {bus.alu_cmd, bus.ra_sel, bus.rb_sel, bus.rf_we, bus.rf_wsel, bus.wdata_sel, bus.imm}, 0);
        // ADD r2,r3 then HALT
        rom[0] = 9'b000_010_011;
        rom[1] = 9'b100_111111;
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(bus.busy), 0);
        pulse_start();
        chk("fetch_addr", 32'(bus.instr_addr), 0);
        chk("fetch_busy", 32'(bus.busy), 1);
        chk("fetch_we", 32'(bus.rf_we), 0);
        tick();
        chk("decode_addr", 32'(bus.instr_addr), 0);
        chk("decode_busy", 32'(bus.busy), 1);
        tick();
        chk("add_addr", 32'(bus.instr_addr), 0);
        chk("add_busy", 32'(bus.busy), 1);
        chk("add_cmd", 32'(bus.alu_cmd), 0);
        chk("add_ra", 32'(bus.ra_sel), 2);
        chk("add_rb", 32'(bus.rb_sel), 3);
        chk("add_we", 32'(bus.rf_we), 1);
        chk("add_wsel", 32'(bus.rf_wsel), 2);
        chk("add_wdsel", 32'(bus.wdata_sel), 0);
        tick();
        chk("add_next", 32'(bus.instr_addr), 1);
        chk("post_exec_we", 32'(bus.rf_we), 0);
        chk("post_exec_ra", 32'(bus.ra_sel), 0);
        tick(2);
        chk("halt1_we", 32'(bus.rf_we), 0);
        tick();
        chk("halt1_done", 32'(bus.done), 1);
        chk("halt1_busy", 32'(bus.busy), 0);
        chk("halt1_pc", 32'(bus.instr_addr), 1);
        // CMP r1,r1 sets flag, BRF -2 at 1 -> 0xFF; LSL keeps flag, wraps to 0; BRF -2 at 0 -> 0xFE
        rom[0] = 9'b111_001_001;
        rom[1] = 9'b010_111110;
        rom[8'hFF] = 9'b001_001_010;
        rom[8'hFE] = 9'b100_111111;
        pulse_start();
        chk("restart_addr", 32'(bus.instr_addr), 0);
        chk("restart_done", 32'(bus.done), 0);
        tick(2);
        chk("cmp_cmd", 32'(bus.alu_cmd), 7);
        chk("cmp_we", 32'(bus.rf_we), 0);
        bus.alu_flag = 1'b1;
        tick();
        bus.alu_flag = 1'b0;
        chk("cmp_next", 32'(bus.instr_addr), 1);
        tick(2);
        chk("brf_we", 32'(bus.rf_we), 0);
        chk("brf_cmd", 32'(bus.alu_cmd), 0);
        tick();
        chk("brf_taken", 32'(bus.instr_addr), 8'hFF);
        rom[0] = 9'b010_111110;
        tick(2);
        chk("lsl_cmd", 32'(bus.alu_cmd), 1);
        chk("lsl_we", 32'(bus.rf_we), 1);
        bus.alu_flag = 1'b1;
        tick();
        bus.alu_flag = 1'b0;
        chk("pc_wrap", 32'(bus.instr_addr), 0);
        tick(3);
        chk("brf_wrap", 32'(bus.instr_addr), 8'hFE);
        tick(3);
        chk("halt2_done", 32'(bus.done), 1);
        // XOR with alu_flag=1 leaves flag clear; BRF +5 at 4 not taken; LI 5; HALT
        rom[0] = 9'b011_001_010;
        rom[1] = 9'd0;
        rom[2] = 9'd0;
        rom[3] = 9'd0;
        rom[4] = 9'b010_000101;
        rom[5] = 9'b100_000101;
        rom[6] = 9'b100_111111;
        pulse_start();
        tick(2);
        chk("xor_cmd", 32'(bus.alu_cmd), 3);
        chk("xor_we", 32'(bus.rf_we), 1);
        bus.alu_flag = 1'b1;
        tick();
        bus.alu_flag = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(8);
        chk("busy_start_ignored", 32'(bus.instr_addr), 4);
        tick(3);
        chk("brf_not_taken", 32'(bus.instr_addr), 5);
        tick(2);
        chk("li_we", 32'(bus.rf_we), 1);
        chk("li_wsel", 32'(bus.rf_wsel), 0);
        chk("li_wdsel", 32'(bus.wdata_sel), 1);
        chk("li_imm", 32'(bus.imm), 5);
        chk("li_cmd", 32'(bus.alu_cmd), 0);
        tick(3);
        chk("halt3_we", 32'(bus.rf_we), 0);
        chk("halt3_busy", 32'(bus.busy), 1);
        tick();
        chk("halt3_done", 32'(bus.done), 1);
        tick(2);
        chk("done_held", 32'(bus.done), 1);
        chk("done_pc", 32'(bus.instr_addr), 6);
        // SUB interrupted by reset during EXEC
        rom[0] = 9'b110_001_010;
        pulse_start();
        chk("start3_addr", 32'(bus.instr_addr), 0);
        chk("start3_done", 32'(bus.done), 0);
        tick(2);
        chk("sub_cmd", 32'(bus.alu_cmd), 6);
        chk("sub_we", 32'(bus.rf_we), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_we", 32'(bus.rf_we), 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_cmd", 32'(bus.alu_cmd), 0);
        #1 rst_n = 1'b1;
        tick(3);
        chk("post_rst_busy", 32'(bus.busy), 0);
        chk("post_rst_addr", 32'(bus.instr_addr), 0);
        pulse_start();
        chk("resume_busy", 32'(bus.busy), 1);
        chk("resume_addr", 32'(bus.instr_addr), 0);
        tick(2);
        chk("resume_sub_cmd", 32'(bus.alu_cmd), 6);
        chk("resume_sub_ra", 32'(bus.ra_sel), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
